// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider C = A / B: restoring division, one quotient bit per clock,
// round-to-nearest-even, denormal inputs and results flushed to zero.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic [EXP_W+MAN_W:0]   C,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam int RW = MAN_W + 2;
  localparam int QW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW + 1);

  localparam logic signed [EW-1:0] BIAS  = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic signed [EW-1:0] EONE  = EW'(1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(QW - 1);
  localparam logic [W-1:0]         QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;
  state_t state, state_nxt;

  logic [RW-1:0]          rem;
  logic [MW-1:0]          mb;
  logic [QW-1:0]          q;
  logic [CW-1:0]          cnt;
  logic signed [EW-1:0]   exp_q;
  logic                   sign_q;

  // Normalise the quotient, round to nearest even and pack; returns {flags, word}.
  function automatic logic [W+3:0] round_pack(input logic [QW-1:0] qv, input logic rem_nz,
                                              input logic signed [EW-1:0] ev, input logic s);
    logic [MW-1:0]        mant;
    logic                 guard, sticky, inc;
    logic [MW:0]          sum;
    logic signed [EW-1:0] e;
    if (qv[QW-1]) begin
      mant = qv[QW-1:3]; guard = qv[2]; sticky = (|qv[1:0]) | rem_nz; e = ev;
    end else begin
      mant = qv[QW-2:2]; guard = qv[1]; sticky = qv[0] | rem_nz; e = ev - EONE;
    end
    inc = guard & (sticky | mant[0]);
    sum = {1'b0, mant} + {{MW{1'b0}}, inc};
    if (sum[MW]) begin
      mant = {1'b1, {MAN_W{1'b0}}};
      e    = e + EONE;
    end else begin
      mant = sum[MW-1:0];
    end
    if (e >= EMAX)       return {4'b0010, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e <= EZERO) return {4'b0001, s, {(W-1){1'b0}}};
    else                 return {4'b0000, s, e[EXP_W-1:0], mant[MAN_W-1:0]};
  endfunction

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             s_res, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic signed [EW-1:0] ea_s, eb_s;
  logic [W-1:0]     spec_c;
  logic [3:0]       spec_f;
  logic [W+3:0]     packed_res;

  assign ea     = A[W-2:MAN_W];
  assign eb     = B[W-2:MAN_W];
  assign fa     = A[MAN_W-1:0];
  assign fb     = B[MAN_W-1:0];
  assign ea_s   = {2'b00, ea};
  assign eb_s   = {2'b00, eb};
  assign s_res  = A[W-1] ^ B[W-1];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  always_comb begin
    spec_c = {s_res, {(W-1){1'b0}}};
    spec_f = 4'b0000;
    if (a_nan | b_nan) begin
      spec_c = QNAN;
    end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
      spec_c = QNAN;
      spec_f = 4'b1000;
    end else if (a_inf | b_zero) begin
      spec_c = {s_res, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_f = {1'b0, b_zero & ~a_inf, 2'b00};
    end
  end

  assign packed_res = round_pack(q, rem != '0, exp_q, sign_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = special ? DONE : DIV;
      DIV:  if (cnt == CNT_LAST) state_nxt = RND;
      RND:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Operand capture and restoring-division iterations
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      rem    <= {2'b01, fa};
      mb     <= {1'b1, fb};
      q      <= '0;
      cnt    <= '0;
      exp_q  <= ea_s - eb_s + BIAS;
      sign_q <= s_res;
    end else if (state == DIV) begin
      if (rem >= {1'b0, mb}) begin
        rem <= (rem - {1'b0, mb}) << 1;
        q   <= {q[QW-2:0], 1'b1};
      end else begin
        rem <= rem << 1;
        q   <= {q[QW-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      C     <= '0;
      flags <= '0;
    end else if (state == IDLE && start && special) begin
      C     <= spec_c;
      flags <= spec_f;
    end else if (state == RND) begin
      C     <= packed_res[W-1:0];
      flags <= packed_res[W+3:W];
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: normal, special, range, handshake and reset-abort scenarios.
module tb_fp_div_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [31:0] C;
  logic        busy, done;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .C(C), .busy(busy), .done(done), .flags(flags)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle; lat counts edges after the start-sampling edge until done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] c, output logic [3:0] f,
                        output int lat, output int busy_lo);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 32'hDEADBEEF; B = 32'h12345678;
    lat = 0; busy_lo = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_lo++;
      @(negedge clk);
      lat++;
    end
    c = C; f = flags;
  endtask

  task automatic test_reset();
    n_checks++; if (C !== 32'h0)   begin n_fail++; $display("FAIL reset_C: got %h want 00000000", C); end
    n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_normal();
    logic [31:0] va[4], vb[4], vc[4], c;
    logic [3:0]  f;
    int lat, blo;
    va[0] = 32'h40C00000; vb[0] = 32'h40000000; vc[0] = 32'h40400000; // 6/2
    va[1] = 32'h3F800000; vb[1] = 32'h40400000; vc[1] = 32'h3EAAAAAB; // 1/3
    va[2] = 32'hC0800000; vb[2] = 32'h40000000; vc[2] = 32'hC0000000; // -4/2
    va[3] = 32'h3F800000; vb[3] = 32'h3F800000; vc[3] = 32'h3F800000; // 1/1
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], c, f, lat, blo);
      n_checks++; if (c !== vc[i]) begin n_fail++; $display("FAIL normal_C[%0d]: got %h want %h", i, c, vc[i]); end
      n_checks++; if (f !== 4'h0) begin n_fail++; $display("FAIL normal_flags[%0d]: got %b want 0000", i, f); end
      n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL normal_latency[%0d]: got %0d want 28", i, lat); end
      n_checks++; if (blo !== 0) begin n_fail++; $display("FAIL normal_busy[%0d]: busy low %0d cycles want 0", i, blo); end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL normal_after_done[%0d]: busy=%b done=%b want 0 0", i, busy, done); end
      n_checks++; if (C !== vc[i]) begin n_fail++; $display("FAIL normal_C_hold[%0d]: got %h want %h", i, C, vc[i]); end
    end
  endtask

  task automatic test_special();
    logic [31:0] va[6], vb[6], vc[6], c;
    logic [3:0]  vf[6], f;
    int lat, blo;
    va[0] = 32'h40800000; vb[0] = 32'h00000000; vc[0] = 32'h7F800000; vf[0] = 4'b0100; // 4/0
    va[1] = 32'h00000000; vb[1] = 32'h00000000; vc[1] = 32'h7FC00000; vf[1] = 4'b1000; // 0/0
    va[2] = 32'h7FC00001; vb[2] = 32'h40800000; vc[2] = 32'h7FC00000; vf[2] = 4'b0000; // NaN
    va[3] = 32'hFF800000; vb[3] = 32'h7F800000; vc[3] = 32'h7FC00000; vf[3] = 4'b1000; // inf/inf
    va[4] = 32'hC0800000; vb[4] = 32'h7F800000; vc[4] = 32'h80000000; vf[4] = 4'b0000; // -4/inf
    va[5] = 32'h00400000; vb[5] = 32'h3F800000; vc[5] = 32'h00000000; vf[5] = 4'b0000; // denormal/1
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], c, f, lat, blo);
      n_checks++; if (c !== vc[i]) begin n_fail++; $display("FAIL special_C[%0d]: got %h want %h", i, c, vc[i]); end
      n_checks++; if (f !== vf[i]) begin n_fail++; $display("FAIL special_flags[%0d]: got %b want %b", i, f, vf[i]); end
      // Special operands raise done on the very edge that samples start.
      n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d want 0", i, lat); end
    end
  endtask

  task automatic test_range();
    logic [31:0] c;
    logic [3:0]  f;
    int lat, blo;
    run_op(32'h7F7FFFFF, 32'h3E800000, c, f, lat, blo);
    n_checks++; if (c !== 32'h7F800000) begin n_fail++; $display("FAIL overflow_C: got %h want 7F800000", c); end
    n_checks++; if (f !== 4'b0010) begin n_fail++; $display("FAIL overflow_flags: got %b want 0010", f); end
    run_op(32'h00800000, 32'h40800000, c, f, lat, blo);
    n_checks++; if (c !== 32'h00000000) begin n_fail++; $display("FAIL underflow_C: got %h want 00000000", c); end
    n_checks++; if (f !== 4'b0001) begin n_fail++; $display("FAIL underflow_flags: got %b want 0001", f); end
  endtask

  task automatic test_ignored_start();
    int ndone = 0;
    logic [31:0] c_seen = '0;
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 32'h3F800000; B = 32'h40400000;
    for (int cyc = 1; cyc < 60; cyc++) begin
      if (done) begin ndone++; c_seen = C; end
      start = (cyc == 5);
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL ignored_start_dones: got %0d want 1", ndone); end
    n_checks++; if (c_seen !== 32'h40400000) begin n_fail++; $display("FAIL ignored_start_C: got %h want 40400000", c_seen); end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    logic [31:0] c2 = '0;
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    for (int cyc = 0; cyc < 100 && second < 0; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = cyc;
        else begin second = cyc; c2 = C; start = 1'b0; end
      end
    end
    start = 1'b0;
    n_checks++; if (second - first !== 30) begin n_fail++; $display("FAIL back_to_back_gap: got %0d want 30 (first=%0d second=%0d)", second - first, first, second); end
    n_checks++; if (c2 !== 32'h40400000) begin n_fail++; $display("FAIL back_to_back_C: got %h want 40400000", c2); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL back_to_back_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    logic [31:0] c;
    logic [3:0]  f;
    int lat, blo;
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
    n_checks++; if (C !== 32'h0) begin n_fail++; $display("FAIL abort_C: got %h want 00000000", C); end
    n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL abort_flags: got %b want 0000", flags); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d dones want 0", ndone); end
    run_op(32'h3F800000, 32'h40400000, c, f, lat, blo);
    n_checks++; if (c !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL abort_fresh_C: got %h want 3EAAAAAB", c); end
    n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL abort_fresh_latency: got %0d want 28", lat); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
